// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ramPckg
// Description : Shared types and constants for the RAM port arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package ramPckg;

  // Read latency of the attached ram for each of its performance modes.
  localparam int cLatLowLatency      = 1;  // "LOW_LATENCY"
  localparam int cLatHighPerformance = 2;  // "HIGH_PERFORMANCE"

  // Default geometry of the ram this arbiter is normally paired with.
  localparam int cDefRamWidth = 32;
  localparam int cDefAddrW    = 10;

  // One RAM access as presented by a requester (default geometry).
  typedef struct packed {
    logic                    we;
    logic [cDefAddrW-1:0]    addr;
    logic [cDefRamWidth-1:0] data;
  } ramReq_t;

  // Arbitration mode: open round-robin, or port held by requester 1.
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arbState_t;

endpackage : ramPckg
`default_nettype wire

// File: rtl/ram_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ram_rsp_pipe
// Description : Shift register of {valid, id} tags that follows each read
//               through the RAM so its data can be routed to the issuer.
// Revision    : 1.0  initial release
// ============================================================================
module ram_rsp_pipe #(
  parameter int cDepth = 3
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iValid,
  input  logic iId,
  output logic oValid,
  output logic oId
);

  logic [cDepth-1:0] valid_q;
  logic [cDepth-1:0] valid_d;
  logic [cDepth-1:0] id_q;
  logic [cDepth-1:0] id_d;

  // Advance every tag one stage per cycle; new tag enters at stage 0.
  always_comb begin
    valid_d = {valid_q[cDepth-2:0], iValid};
    id_d    = {id_q[cDepth-2:0], iId};
  end

  // Tag registers; reset drops every read in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign oValid = valid_q[cDepth-1];
  assign oId    = id_q[cDepth-1];

endmodule : ram_rsp_pipe
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter for one ram port shared by the load/store
//               unit (requester 0) and the loader/debug port (requester 1),
//               with a requester-1 lock, registered RAM command and
//               read-response routing.
// Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter
  import ramPckg::*;
#(
  parameter int cRamWidth    = 32,
  parameter int cRamDepth    = 1024,
  parameter int cReadLatency = cLatHighPerformance,
  localparam int cAddrW      = $clog2(cRamDepth)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iReq0,
  input  logic                 iWe0,
  input  logic [cAddrW-1:0]    iAddr0,
  input  logic [cRamWidth-1:0] iData0,
  input  logic                 iReq1,
  input  logic                 iWe1,
  input  logic [cAddrW-1:0]    iAddr1,
  input  logic [cRamWidth-1:0] iData1,
  input  logic                 iLock1,
  output logic                 oGnt0,
  output logic                 oGnt1,
  output logic                 oRValid0,
  output logic                 oRValid1,
  output logic [cRamWidth-1:0] oRData,
  output logic                 oRamEn,
  output logic                 oRamWEn,
  output logic [cAddrW-1:0]    oRamAddr,
  output logic [cRamWidth-1:0] oRamData,
  input  logic [cRamWidth-1:0] iRamData
);

  arbState_t            state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_wen_q, ram_wen_d;
  logic [cAddrW-1:0]    ram_addr_q, ram_addr_d;
  logic [cRamWidth-1:0] ram_data_q, ram_data_d;

  logic gnt0;
  logic gnt1;
  logic rsp_valid;
  logic rsp_id;
  logic pipe_valid;
  logic pipe_id;

  // Grant selection, next state, pointer and next RAM command.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    ram_en_d   = 1'b0;
    ram_wen_d  = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;

    if (!iRst) begin
      // Dropping iLock1 releases the lock in the same cycle.
      if (state_q == LOCK && iLock1) begin
        gnt1 = iReq1;
      end else if (iReq0 && iReq1) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = iReq0;
        gnt1 = iReq1;
      end
    end

    if (!iLock1) begin
      state_d = ARB;
    end else if (gnt1) begin
      state_d = LOCK;
    end

    if (gnt0) begin
      last_gnt_d = 1'b0;
      ram_en_d   = 1'b1;
      ram_wen_d  = iWe0;
      ram_addr_d = iAddr0;
      ram_data_d = iData0;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
      ram_en_d   = 1'b1;
      ram_wen_d  = iWe1;
      ram_addr_d = iAddr1;
      ram_data_d = iData1;
    end

    // Only reads need their data routed back.
    rsp_valid = (gnt0 && !iWe0) || (gnt1 && !iWe1);
    rsp_id    = gnt1;
  end

  // Arbiter state and registered RAM command.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ARB;
      last_gnt_q <= 1'b1;
      ram_en_q   <= 1'b0;
      ram_wen_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      ram_en_q   <= ram_en_d;
      ram_wen_q  <= ram_wen_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  // One stage for the command register plus one per RAM latency cycle.
  ram_rsp_pipe #(
    .cDepth (cReadLatency + 1)
  ) u_rsp_pipe (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (rsp_valid),
    .iId    (rsp_id),
    .oValid (pipe_valid),
    .oId    (pipe_id)
  );

  assign oGnt0    = gnt0;
  assign oGnt1    = gnt1;
  assign oRamEn   = ram_en_q;
  assign oRamWEn  = ram_wen_q;
  assign oRamAddr = ram_addr_q;
  assign oRamData = ram_data_q;
  assign oRValid0 = pipe_valid && !pipe_id;
  assign oRValid1 = pipe_valid && pipe_id;
  assign oRData   = iRamData;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Bench for ram_arbiter at read latencies 2 and 1, with a
//               behavioural ram and a transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  typedef struct {
    int          due;
    bit          id;
    logic [W-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req0, we0, req1, we1, lock1, mem_init;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  data0, data1;

  // instance A: latency 2, instance B: latency 1
  logic          gnt0_a, gnt1_a, rv0_a, rv1_a, en_a, wen_a;
  logic          gnt0_b, gnt1_b, rv0_b, rv1_b, en_b, wen_b;
  logic [AW-1:0] raddr_a, raddr_b;
  logic [W-1:0]  rdata_a, rdata_b, wdata_a, wdata_b, ramq_a, ramq_b;

  ram_arbiter #(.cRamWidth(W), .cRamDepth(DEPTH), .cReadLatency(2)) dut_l2 (
    .iClk(clk), .iRst(rst),
    .iReq0(req0), .iWe0(we0), .iAddr0(addr0), .iData0(data0),
    .iReq1(req1), .iWe1(we1), .iAddr1(addr1), .iData1(data1),
    .iLock1(lock1),
    .oGnt0(gnt0_a), .oGnt1(gnt1_a), .oRValid0(rv0_a), .oRValid1(rv1_a),
    .oRData(rdata_a), .oRamEn(en_a), .oRamWEn(wen_a), .oRamAddr(raddr_a),
    .oRamData(wdata_a), .iRamData(ramq_a)
  );

  ram_arbiter #(.cRamWidth(W), .cRamDepth(DEPTH), .cReadLatency(1)) dut_l1 (
    .iClk(clk), .iRst(rst),
    .iReq0(req0), .iWe0(we0), .iAddr0(addr0), .iData0(data0),
    .iReq1(req1), .iWe1(we1), .iAddr1(addr1), .iData1(data1),
    .iLock1(lock1),
    .oGnt0(gnt0_b), .oGnt1(gnt1_b), .oRValid0(rv0_b), .oRValid1(rv1_b),
    .oRData(rdata_b), .oRamEn(en_b), .oRamWEn(wen_b), .oRamAddr(raddr_b),
    .oRamData(wdata_b), .iRamData(ramq_b)
  );

  function automatic logic [W-1:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Behavioural read-first ram; both instances issue identical commands,
  // so writes are taken from instance A only.
  logic [W-1:0] ram_mem [DEPTH];
  logic [W-1:0] rd_a1, rd_a2, rd_b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
    end else if (en_a && wen_a) begin
      ram_mem[raddr_a] <= wdata_a;
    end
    if (en_a) rd_a1 <= ram_mem[raddr_a];
    rd_a2 <= rd_a1;
    if (en_b) rd_b1 <= ram_mem[raddr_b];
  end
  assign ramq_a = rd_a2;
  assign ramq_b = rd_b1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction level, evaluated once per cycle at negedge.
  logic [W-1:0] ref_mem [DEPTH];
  bit           m_valid = 1'b0;
  bit           m_locked, m_last;
  bit           exp_en, exp_wen;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  rsp_t         q2 [$];
  rsp_t         q1 [$];
  int           cyc = 0;

  always @(negedge clk) begin
    bit g0, g1, ev0, ev1;
    logic [W-1:0] ed;
    cyc++;
    g0 = 1'b0;
    g1 = 1'b0;
    if (m_valid) begin
      // registered command from the previous cycle's grant
      check("a_en", en_a, exp_en);   check("b_en", en_b, exp_en);
      check("a_wen", wen_a, exp_wen); check("b_wen", wen_b, exp_wen);
      check("a_addr", raddr_a, exp_addr); check("b_addr", raddr_b, exp_addr);
      check("a_wdata", wdata_a, exp_data); check("b_wdata", wdata_b, exp_data);

      // responses due this cycle
      ev0 = 0; ev1 = 0; ed = '0;
      if (q2.size() > 0 && q2[0].due == cyc) begin
        ev0 = !q2[0].id; ev1 = q2[0].id; ed = q2[0].data; void'(q2.pop_front());
      end
      check("a_rvalid0", rv0_a, ev0); check("a_rvalid1", rv1_a, ev1);
      if (ev0 || ev1) check("a_rdata", rdata_a, ed);
      ev0 = 0; ev1 = 0; ed = '0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        ev0 = !q1[0].id; ev1 = q1[0].id; ed = q1[0].data; void'(q1.pop_front());
      end
      check("b_rvalid0", rv0_b, ev0); check("b_rvalid1", rv1_b, ev1);
      if (ev0 || ev1) check("b_rdata", rdata_b, ed);

      // who should win this cycle
      if (!rst) begin
        if (m_locked && lock1) g1 = req1;
        else if (req0 && req1) begin g0 = m_last; g1 = !m_last; end
        else begin g0 = req0; g1 = req1; end
      end
      check("a_gnt0", gnt0_a, g0); check("a_gnt1", gnt1_a, g1);
      check("b_gnt0", gnt0_b, g0); check("b_gnt1", gnt1_b, g1);
    end

    if (rst) begin
      m_valid = 1'b1; m_locked = 1'b0; m_last = 1'b1;
      exp_en = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_data = '0;
      q2.delete(); q1.delete();
      if (mem_init) for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    end else if (m_valid) begin
      m_locked = lock1 ? (m_locked || g1) : 1'b0;
      exp_en   = g0 || g1;
      exp_wen  = 1'b0;
      if (g0 || g1) begin
        rsp_t r;
        m_last   = g1;
        exp_wen  = g0 ? we0 : we1;
        exp_addr = g0 ? addr0 : addr1;
        exp_data = g0 ? data0 : data1;
        if (exp_wen) begin
          ref_mem[exp_addr] = exp_data;
        end else begin
          r.id = g1; r.data = ref_mem[exp_addr];
          r.due = cyc + 3; q2.push_back(r);
          r.due = cyc + 2; q1.push_back(r);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit q0, input bit w0, input int a0, input logic [W-1:0] d0,
                       input bit q1v, input bit w1, input int a1, input logic [W-1:0] d1, input bit l1);
    rst = r; req0 = q0; we0 = w0; addr0 = AW'(a0); data0 = d0;
    req1 = q1v; we1 = w1; addr1 = AW'(a1); data1 = d1; lock1 = l1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mem_init = 1'b1;
    rst = 1'b1; req0 = 0; we0 = 0; addr0 = '0; data0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; data1 = '0; lock1 = 0;
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_init = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single read of address 5
    drive(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    idle(5);

    // conflict fairness straight after reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 10 + i, 0, 1, 0, 20 + i, 0, 0);
    idle(5);

    // lock: requester 0 held off until iLock1 drops
    drive(0, 1, 0, 30, 0, 1, 0, 40, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 31, 0, 1, 0, 41 + i, 0, 1);
    drive(0, 1, 0, 32, 0, 1, 0, 44, 0, 0);
    drive(0, 1, 0, 33, 0, 1, 0, 45, 0, 0);
    idle(5);

    // write then read across requesters at the top address
    drive(0, 0, 0, 0, 0, 1, 1, 'h3FF, 32'h12345678, 0);
    idle(1);
    drive(0, 1, 0, 'h3FF, 0, 0, 0, 0, 0, 0);
    idle(5);

    // reset with reads in flight
    for (int i = 1; i <= 3; i++) drive(0, 1, 0, i, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    drive(0, 1, 0, 7, 0, 1, 0, 8, 0, 0);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, a0, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, a1, $urandom,
            $urandom_range(0, 9) < 4);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for one port of the dual-port `ram` block. It shares a single RAM port between the core load/store unit (requester 0) and the program loader/debug port (requester 1). Arbitration is round-robin, and requester 1 can optionally lock the port for a burst. The block registers the RAM command, tracks read latency, and routes each read response back to the requester that issued it.

## Interface
Parameters:
- cRamWidth, 32, data width; must match the attached `ram`.
- cRamDepth, 1024, RAM depth; address width cAddrW = $clog2(cRamDepth).
- cReadLatency, 2, cycles from RAM command to valid iRamData. 1 for "LOW_LATENCY", 2 for "HIGH_PERFORMANCE"; legal values 1..2.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset. Synchronous, active-high.
- iReq0 / iReq1  in  1  access request from requester 0 / 1.
- iWe0 / iWe1  in  1  1 = write, 0 = read.
- iAddr0 / iAddr1  in  cAddrW  word address.
- iData0 / iData1  in  cRamWidth  write data.
- iLock1  in  1  requester 1 lock request.
- oGnt0 / oGnt1  out  1  request accepted this cycle.
- oRValid0 / oRValid1  out  1  read data valid for that requester.
- oRData  out  cRamWidth  read data, shared by both requesters.
- oRamEn  out  1  RAM port enable.
- oRamWEn  out  1  RAM port write enable.
- oRamAddr  out  cAddrW  RAM address.
- oRamData  out  cRamWidth  RAM write data.
- iRamData  in  cRamWidth  RAM read data.

## Operation
- A transfer occurs on a cycle where iReqX=1 and oGntX=1. Grants are combinational from the requests, the state and the pointer.
- At most one grant per cycle. The block accepts one access per cycle and never stalls on outstanding reads.
- Round-robin pointer lastGnt (1 bit):
  - Both requesting → grant the requester that is not lastGnt.
  - Single requester → grant it.
  - lastGnt updates only on a grant.
- State machine:
  - ARB: round-robin as above.
  - ARB → LOCK: requester 1 granted with iLock1=1.
  - LOCK: only requester 1 can be granted; oGnt0=0 regardless of iReq0.
  - LOCK → ARB: on any cycle with iLock1=0. That cycle already arbitrates as ARB, so the exit is combinational on iLock1.
- Command register: on a grant, the next cycle carries oRamEn=1, oRamWEn=iWeX, oRamAddr=iAddrX, oRamData=iDataX. With no grant, oRamEn=0 and oRamWEn=0; addr/data hold their last values.
- Response pipeline: cReadLatency+1 stages of {valid, id}. A stage is loaded only for granted reads; writes produce no response.
- The pipeline output drives oRValid0 (id=0) or oRValid1 (id=1). oRData = iRamData directly, with no extra register.
- Same-address read and write from different requesters return old or new data according to the `ram` read-first behaviour; the arbiter does no forwarding.

## Timing
- Reset, applied on a clock edge with iRst=1:
  - State = ARB, lastGnt = 1 (requester 0 wins the first conflict).
  - oRamEn = 0, oRamWEn = 0, oRamAddr = 0, oRamData = 0.
  - All pipeline valid bits = 0, so oRValid0 = oRValid1 = 0.
- While iRst=1, oGnt0 = oGnt1 = 0.
- Reset mid-operation drops in-flight reads: no oRValid is asserted for them after reset.
- Latency:
  - Grant at cycle N → RAM command at N+1 → oRValidX at N+1+cReadLatency.
  - Read-to-response totals: 2 cycles for cReadLatency=1, 3 cycles for cReadLatency=2.
- Back-to-back grants give back-to-back responses in grant order, one per cycle.
- oRData is meaningful only while some oRValidX=1.

## Structure
- Package `ramPckg`:
  - typedef `ramReq_t` = {we, addr, data}.
  - enum `arbState_t` = {ARB, LOCK}.
  - constants for the cReadLatency mapping from the `ram` performance string.
- Sub-module `ram_rsp_pipe`: parameterised-depth shift register of {valid, id} with synchronous clear. Everything else stays in ram_arbiter.
- Top-level integration instantiates `ram_arbiter` next to `ram` and connects oRamEn/oRamWEn/oRamAddr/oRamData/iRamData to port B.

## Test plan
- Single read: cReadLatency=2, mem[5]=0xDEADBEEF, iReq0 read addr 5 at cycle N → oGnt0=1 at N, oRamEn=1 and oRamAddr=5 at N+1, oRValid0=1 with oRData=0xDEADBEEF at N+3, oRValid1=0 throughout.
- Conflict fairness: iReq0=iReq1=1 for 4 cycles right after reset → grants 0,1,0,1; each read returns on the matching oRValidX.
- Lock: requester 1 granted with iLock1=1 and iReq0 held high → oGnt0=0 until the cycle iLock1=0; that same cycle requester 0 is granted if lastGnt=1.
- Write then read: requester 1 writes 0x12345678 to addr 0x3FF; requester 0 reads 0x3FF two cycles later → oRValid0 with oRData=0x12345678; the write produces no oRValid.
- Reset mid-flight: grant three reads, assert iRst one cycle later → no oRValid0/oRValid1 pulses afterwards, oRamEn=0, and requester 0 wins the next conflict.
- Latency sweep: repeat scenario 1 with cReadLatency=1 → oRValid0 at N+2.
